mem_arbiter: RTL and testbench

- Shares one synchronous single-port memory between the core's instruction-fetch port and its load/store data port.
- Grants at most one access per cycle, with data-over-fetch priority plus a starvation guard for fetch.
- Returns read data with fixed one-cycle latency to the port that issued the read.
- Flags misaligned word accesses instead of issuing them.
- Sits between the pipelined core and the unified RAM, so that RAM and ROM-image storage collapse into one physical array.

---
 rtl/mem_arbiter.sv | 74 +++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store data,
// data-over-fetch priority with a starvation guard and a one-cycle read response pipeline.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    logic                  run;
    logic [3:0]            starve_cnt;
    logic [ADDR_WIDTH-3:0] last_addr;
    logic                  rsp_valid;
    logic                  rsp_data;
    logic                  rsp_err;
    logic                  if_mis;
    logic                  d_mis;

    assign if_mis = |if_addr[1:0];
    assign d_mis  = |d_addr[1:0];

    // run keeps every grant low until the first clock edge after reset release
    assign d_gnt  = run & d_req & ~(if_req & (starve_cnt >= 4'(STARVE_LIMIT)));
    assign if_gnt = run & if_req & ~d_gnt;

    assign mem_addr  = if_gnt ? if_addr[ADDR_WIDTH-1:2] : d_gnt ? d_addr[ADDR_WIDTH-1:2] : last_addr;
    assign mem_we    = d_gnt & d_we & ~d_mis;
    assign mem_wdata = d_gnt ? d_wdata : '0;

    assign if_rvalid = rsp_valid & ~rsp_data;
    assign d_rvalid  = rsp_valid & rsp_data;
    assign if_err    = if_rvalid & rsp_err;
    assign d_err     = d_rvalid & rsp_err;
    assign if_rdata  = (if_rvalid & ~rsp_err) ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid & ~rsp_err) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            starve_cnt <= '0;
            last_addr  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            run        <= 1'b1;
            starve_cnt <= (!run || !if_req || if_gnt) ? 4'd0 : (starve_cnt == 4'd15) ? 4'd15 : starve_cnt + 4'd1;
            if (if_gnt || d_gnt)
                last_addr <= mem_addr;
            // aligned stores complete silently; reads and any misaligned access answer next cycle
            rsp_valid  <= if_gnt | (d_gnt & (~d_we | d_mis));
            rsp_data   <= d_gnt;
            rsp_err    <= if_gnt ? if_mis : d_mis;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a word-array reference model, a write-first RAM,
// directed scenarios and a randomized phase.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        q_if[$];
    rsp_t        q_d[$];
    logic [31:0] ram[256];
    logic [31:0] ref_mem[256];
    bit          init_done = 0;
    bit          alive = 0;
    bit          g_if, g_d;
    int          cyc = 0;
    int          m_starve = 0;
    int          passes = 0;
    int          checks = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // write-first RAM, reloaded from the reference image while reset is held
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem_we ? mem_wdata : ram[mem_addr[7:0]];
    end

    always @(posedge clk) begin
        cyc   = cyc + 1;
        alive = rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    // reference model: grant rule, starvation count and memory image at transaction level
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
            ref_mem[0] = 32'h00000013;
            ref_mem[1] = 32'h00100093;
            ref_mem[2] = 32'h00200113;
            init_done = 1;
        end
        if (!(rst_n && alive)) begin
            m_starve = 0;
            chk("idle_d_gnt", d_gnt, 0);
            chk("idle_if_gnt", if_gnt, 0);
            chk("idle_mem_we", mem_we, 0);
            chk("idle_mem_wdata", mem_wdata, 0);
            chk("idle_mem_addr", {2'b0, mem_addr}, 0);
            chk("idle_rvalid", {if_rvalid, d_rvalid, if_err, d_err}, 0);
            chk("idle_rdata", if_rdata | d_rdata, 0);
        end else begin
            bit e_d, e_if, e_we;
            e_d  = d_req && !(if_req && m_starve >= 4);
            e_if = if_req && !e_d;
            e_we = e_d && d_we && d_addr[1:0] == 2'b00;
            chk("d_gnt", d_gnt, e_d);
            chk("if_gnt", if_gnt, e_if);
            chk("mem_we", mem_we, e_we);
            if (e_if) begin
                chk("mem_addr_if", {2'b0, mem_addr}, if_addr >> 2);
                if (if_addr[1:0] != 2'b00) q_if.push_back('{32'h0, 1'b1, cyc + 1});
                else q_if.push_back('{ref_mem[if_addr[9:2]], 1'b0, cyc + 1});
            end
            if (e_d) begin
                chk("mem_addr_d", {2'b0, mem_addr}, d_addr >> 2);
                if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
                if (d_addr[1:0] != 2'b00) q_d.push_back('{32'h0, 1'b1, cyc + 1});
                else if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
                else q_d.push_back('{ref_mem[d_addr[9:2]], 1'b0, cyc + 1});
            end
            m_starve = (if_req && !e_if) ? m_starve + 1 : 0;
        end
    end

    // monitor: compares every response the DUT presents against the scoreboard queues
    task automatic mon(input bit is_d, input logic v, input logic [31:0] rd, input logic e);
        bit   due;
        rsp_t r;
        if (is_d) begin
            while (q_d.size() > 0 && q_d[0].due < cyc) void'(q_d.pop_front());
            due = q_d.size() > 0 && q_d[0].due == cyc;
        end else begin
            while (q_if.size() > 0 && q_if[0].due < cyc) void'(q_if.pop_front());
            due = q_if.size() > 0 && q_if[0].due == cyc;
        end
        chk(is_d ? "d_rvalid" : "if_rvalid", v, due);
        if (due && v) begin
            r = is_d ? q_d.pop_front() : q_if.pop_front();
            chk(is_d ? "d_rdata" : "if_rdata", rd, r.data);
            chk(is_d ? "d_err" : "if_err", e, r.err);
        end else if (!v) begin
            chk(is_d ? "d_rdata_quiet" : "if_rdata_quiet", {rd[31:1], rd[0] | e}, 0);
        end
    endtask

    always @(negedge clk) begin
        g_if = if_gnt;
        g_d  = d_gnt;
        if (rst_n) begin
            mon(1'b0, if_rvalid, if_rdata, if_err);
            mon(1'b1, d_rvalid, d_rdata, d_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_d);
        int n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (is_d ? g_d : g_if) break;
            if (++n > 20) begin
                chk(is_d ? "d_gnt_timeout" : "if_gnt_timeout", 0, 1);
                break;
            end
        end
        step();
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        wait_gnt(1'b0);
        if_req = 1'b0;
    endtask

    task automatic d_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        wait_gnt(1'b1);
        d_req = 1'b0;
    endtask

    task automatic contention();
        if_req = 1'b1; if_addr = 32'h0c;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        repeat (6) step();
        if_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        step();
        fetch(32'h00); fetch(32'h04); fetch(32'h08);
        repeat (2) step();
        contention();
        d_op(1'b1, 32'h20, 32'hDEADBEEF);
        d_op(1'b0, 32'h20, 32'h0);
        step();
        d_op(1'b1, 32'h22, 32'h12345678);
        d_op(1'b0, 32'h20, 32'h0);
        fetch(32'h06);
        step();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        if_req = 1'b1; if_addr = 32'h10;
        step();
        if_req = 1'b0;
        repeat (3) step();
        d_req = 1'b0;
        step();
        contention();
        // reset while a fetch response is in flight
        if_req = 1'b1; if_addr = 32'h10;
        wait_gnt(1'b0);
        @(negedge clk); #1;
        if_req = 1'b1; if_addr = 32'h14;
        @(posedge clk); #3;
        rst_n = 1'b0; if_req = 1'b0;
        q_if.delete(); q_d.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 600; i++) begin
            if (!(if_req && !g_if && $urandom_range(0, 9) != 0)) begin
                if_req  = $urandom_range(0, 1) == 1;
                if_addr = rand_addr();
            end
            if (!(d_req && !g_d && $urandom_range(0, 9) != 0)) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
